// File: rtl/bp_fpga_host_pkg.sv
// Shared NBF packet definitions for the FPGA host link.
package bp_fpga_host_pkg;

  localparam int unsigned NBF_OPCODE_W = 8;
  localparam int unsigned NBF_ADDR_W   = 40;
  localparam int unsigned NBF_DATA_W   = 64;
  localparam int unsigned NBF_W        = NBF_OPCODE_W + NBF_ADDR_W + NBF_DATA_W;
  localparam int unsigned NBF_BYTES    = NBF_W / 8;
  localparam int unsigned NBF_IDX_W    = 4;

  localparam logic [NBF_IDX_W-1:0] NBF_LAST_IDX = NBF_IDX_W'(NBF_BYTES - 1);

  localparam logic [NBF_OPCODE_W-1:0] NBF_OP_WRITE  = 8'h03;
  localparam logic [NBF_OPCODE_W-1:0] NBF_OP_READ   = 8'h13;
  localparam logic [NBF_OPCODE_W-1:0] NBF_OP_FENCE  = 8'hFE;
  localparam logic [NBF_OPCODE_W-1:0] NBF_OP_FINISH = 8'hFF;

  typedef struct packed {
    logic [NBF_OPCODE_W-1:0] opcode;
    logic [NBF_ADDR_W-1:0]   addr;
    logic [NBF_DATA_W-1:0]   data;
  } bp_nbf_s;

  // Byte k of a packet is bits [8k+7:8k]; byte 0 is data[7:0].
  function automatic logic [7:0] nbf_byte(input logic [NBF_W-1:0] pkt,
                                          input logic [NBF_IDX_W-1:0] idx);
    logic [7:0] b;
    b = '0;
    for (int unsigned k = 0; k < NBF_BYTES; k++) begin
      if (idx == NBF_IDX_W'(k)) b = pkt[8*k +: 8];
    end
    return b;
  endfunction

endpackage

// File: rtl/bp_nbf_uart_rx_assembler.sv
// Reassembles a UART byte stream into NBF packets with an inter-byte idle timeout.
module bp_nbf_uart_rx_assembler
  import bp_fpga_host_pkg::*;
#(
  parameter int unsigned rx_timeout_cycles_p = 1000000
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [7:0]       rx_i,
  input  logic             rx_v_i,
  output logic             rx_yumi_o,
  output logic [NBF_W-1:0] nbf_o,
  output logic             nbf_v_o,
  input  logic             nbf_ready_and_i,
  output logic             rx_timeout_o,
  output logic [31:0]      rx_pkt_count_o
);

  localparam int unsigned BUF_W   = NBF_W - 8;
  localparam int unsigned IDLE_W  = (rx_timeout_cycles_p < 2) ? 1 : $clog2(rx_timeout_cycles_p + 1);
  localparam bit          TMO_EN  = (rx_timeout_cycles_p != 0);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(rx_timeout_cycles_p);

  typedef enum logic {RX_COLLECT, RX_HOLD} rx_state_e;

  rx_state_e              state_q, state_d;
  logic [NBF_IDX_W-1:0]   idx_q, idx_d;
  logic [BUF_W-1:0]       buf_q, buf_d;
  bp_nbf_s                nbf_q, nbf_d;
  logic                   nbf_v_q, nbf_v_d;
  logic [IDLE_W-1:0]      idle_q, idle_d;
  logic [31:0]            cnt_q, cnt_d;
  logic                   yumi;
  logic                   timeout;
  logic [NBF_IDX_W-1:0]   wr_idx;

  // Consume whenever collecting; held off during reset so outputs read as reset values.
  assign yumi    = rx_v_i & (state_q == RX_COLLECT) & reset_n_i;
  // Timeout is a decode of registered state only.
  assign timeout = TMO_EN && (state_q == RX_COLLECT) && (idx_q != '0) && (idle_q == IDLE_LIMIT);

  assign rx_yumi_o      = yumi;
  assign nbf_o          = nbf_q;
  assign nbf_v_o        = nbf_v_q;
  assign rx_timeout_o   = timeout;
  assign rx_pkt_count_o = cnt_q;

  // Next-state: byte deposit, idle counting, hold until the consumer accepts.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    nbf_d   = nbf_q;
    nbf_v_d = nbf_v_q;
    idle_d  = idle_q;
    cnt_d   = cnt_q;
    wr_idx  = idx_q;
    unique case (state_q)
      RX_COLLECT: begin
        if (timeout) begin
          idx_d  = '0;
          idle_d = '0;
          wr_idx = '0;
        end else if (idx_q == '0) begin
          idle_d = '0;
        end else if (!yumi && TMO_EN) begin
          idle_d = idle_q + IDLE_W'(1);
        end
        if (yumi) begin
          idle_d = '0;
          if (wr_idx == NBF_LAST_IDX) begin
            nbf_d.opcode = rx_i;
            nbf_d.addr   = buf_q[NBF_DATA_W +: NBF_ADDR_W];
            nbf_d.data   = buf_q[NBF_DATA_W-1:0];
            nbf_v_d      = 1'b1;
            idx_d        = '0;
            state_d      = RX_HOLD;
          end else begin
            for (int unsigned k = 0; k < NBF_BYTES - 1; k++) begin
              if (wr_idx == NBF_IDX_W'(k)) buf_d[8*k +: 8] = rx_i;
            end
            idx_d = wr_idx + NBF_IDX_W'(1);
          end
        end
      end
      RX_HOLD: begin
        if (nbf_ready_and_i) begin
          nbf_v_d = 1'b0;
          idx_d   = '0;
          cnt_d   = cnt_q + 32'd1;
          state_d = RX_COLLECT;
        end
      end
      default: state_d = RX_COLLECT;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= RX_COLLECT;
      idx_q   <= '0;
      buf_q   <= '0;
      nbf_q   <= '0;
      nbf_v_q <= 1'b0;
      idle_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      nbf_q   <= nbf_d;
      nbf_v_q <= nbf_v_d;
      idle_q  <= idle_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/bp_nbf_uart_endpoint.sv
// Host-side NBF-over-UART endpoint: serializes outbound packets, reassembles inbound ones.
module bp_nbf_uart_endpoint
  import bp_fpga_host_pkg::*;
#(
  parameter int unsigned nbf_addr_width_p    = 40,
  parameter int unsigned nbf_data_width_p    = 64,
  parameter int unsigned nbf_opcode_width_p  = 8,
  parameter int unsigned uart_data_bits_p    = 8,
  parameter int unsigned rx_timeout_cycles_p = 1000000
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [NBF_W-1:0] nbf_i,
  input  logic             nbf_v_i,
  output logic             nbf_ready_and_o,
  output logic [7:0]       tx_o,
  output logic             tx_v_o,
  input  logic             tx_ready_and_i,
  input  logic [7:0]       rx_i,
  input  logic             rx_v_i,
  output logic             rx_yumi_o,
  output logic [NBF_W-1:0] nbf_o,
  output logic             nbf_v_o,
  input  logic             nbf_ready_and_i,
  output logic             rx_timeout_o,
  output logic [31:0]      tx_pkt_count_o,
  output logic [31:0]      rx_pkt_count_o
);

  // Only the fixed 112-bit NBF layout over 8-bit UART is supported.
  if (nbf_addr_width_p != 40) begin : g_bad_addr
    $fatal(1, "bp_nbf_uart_endpoint: nbf_addr_width_p must be 40");
  end
  if (nbf_data_width_p != 64) begin : g_bad_data
    $fatal(1, "bp_nbf_uart_endpoint: nbf_data_width_p must be 64");
  end
  if (nbf_opcode_width_p != 8) begin : g_bad_opcode
    $fatal(1, "bp_nbf_uart_endpoint: nbf_opcode_width_p must be 8");
  end
  if (uart_data_bits_p != 8) begin : g_bad_uart
    $fatal(1, "bp_nbf_uart_endpoint: uart_data_bits_p must be 8");
  end

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;

  tx_state_e            tx_state_q, tx_state_d;
  bp_nbf_s              pkt_q, pkt_d;
  logic [NBF_IDX_W-1:0] tx_idx_q, tx_idx_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic                 tx_v_q, tx_v_d;
  logic                 ready_q, ready_d;
  logic [31:0]          tx_cnt_q, tx_cnt_d;

  assign nbf_ready_and_o = ready_q;
  assign tx_o            = tx_byte_q;
  assign tx_v_o          = tx_v_q;
  assign tx_pkt_count_o  = tx_cnt_q;

  // TX next-state: latch a packet, then present its 14 bytes one handshake at a time.
  always_comb begin
    tx_state_d = tx_state_q;
    pkt_d      = pkt_q;
    tx_idx_d   = tx_idx_q;
    tx_byte_d  = tx_byte_q;
    tx_v_d     = tx_v_q;
    ready_d    = ready_q;
    tx_cnt_d   = tx_cnt_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (nbf_v_i) begin
          pkt_d      = nbf_i;
          tx_idx_d   = '0;
          tx_byte_d  = nbf_i[7:0];
          tx_v_d     = 1'b1;
          ready_d    = 1'b0;
          tx_state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        if (tx_ready_and_i) begin
          if (tx_idx_q == NBF_LAST_IDX) begin
            tx_v_d     = 1'b0;
            ready_d    = 1'b1;
            tx_cnt_d   = tx_cnt_q + 32'd1;
            tx_state_d = TX_IDLE;
          end else begin
            tx_idx_d  = tx_idx_q + NBF_IDX_W'(1);
            tx_byte_d = nbf_byte(pkt_q, tx_idx_q + NBF_IDX_W'(1));
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // TX registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tx_state_q <= TX_IDLE;
      pkt_q      <= '0;
      tx_idx_q   <= '0;
      tx_byte_q  <= '0;
      tx_v_q     <= 1'b0;
      ready_q    <= 1'b1;
      tx_cnt_q   <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      pkt_q      <= pkt_d;
      tx_idx_q   <= tx_idx_d;
      tx_byte_q  <= tx_byte_d;
      tx_v_q     <= tx_v_d;
      ready_q    <= ready_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

  bp_nbf_uart_rx_assembler #(
    .rx_timeout_cycles_p(rx_timeout_cycles_p)
  ) u_rx (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .rx_i           (rx_i),
    .rx_v_i         (rx_v_i),
    .rx_yumi_o      (rx_yumi_o),
    .nbf_o          (nbf_o),
    .nbf_v_o        (nbf_v_o),
    .nbf_ready_and_i(nbf_ready_and_i),
    .rx_timeout_o   (rx_timeout_o),
    .rx_pkt_count_o (rx_pkt_count_o)
  );

endmodule

// File: tb/tb_bp_nbf_uart_endpoint.sv
// Scoreboard bench for the NBF-over-UART endpoint.
module tb_bp_nbf_uart_endpoint;

  localparam int unsigned TMO = 16;

  logic         clk_i = 1'b0;
  logic         reset_n_i = 1'b0;
  logic [111:0] nbf_i = '0;
  logic         nbf_v_i = 1'b0;
  logic         nbf_ready_and_o;
  logic [7:0]   tx_o;
  logic         tx_v_o;
  logic         tx_ready_and_i = 1'b0;
  logic [7:0]   rx_i = '0;
  logic         rx_v_i = 1'b0;
  logic         rx_yumi_o;
  logic [111:0] nbf_o;
  logic         nbf_v_o;
  logic         nbf_ready_and_i = 1'b0;
  logic         rx_timeout_o;
  logic [31:0]  tx_pkt_count_o;
  logic [31:0]  rx_pkt_count_o;

  always #5 clk_i = ~clk_i;

  bp_nbf_uart_endpoint #(.rx_timeout_cycles_p(TMO)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .nbf_i(nbf_i), .nbf_v_i(nbf_v_i), .nbf_ready_and_o(nbf_ready_and_o),
    .tx_o(tx_o), .tx_v_o(tx_v_o), .tx_ready_and_i(tx_ready_and_i),
    .rx_i(rx_i), .rx_v_i(rx_v_i), .rx_yumi_o(rx_yumi_o),
    .nbf_o(nbf_o), .nbf_v_o(nbf_v_o), .nbf_ready_and_i(nbf_ready_and_i),
    .rx_timeout_o(rx_timeout_o),
    .tx_pkt_count_o(tx_pkt_count_o), .rx_pkt_count_o(rx_pkt_count_o)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0]   tx_exp_q[$];
  logic [111:0] rx_exp_q[$];
  bit sb_en = 1'b0;
  int tx_rdy_mode = 1;   // 0 low, 1 high, 2 random, 3 toggle
  int rx_rdy_mode = 1;
  int tmo_pulses = 0;
  int tx_sent = 0;
  int rx_sent = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  function automatic logic [111:0] rand_pkt();
    logic [7:0] ops [4];
    ops = '{8'h03, 8'h13, 8'hFE, 8'hFF};
    return {ops[$urandom_range(0, 3)], 8'($urandom), $urandom, $urandom, $urandom};
  endfunction

  // Ready generators for both sink-side handshakes.
  initial begin
    forever begin
      @(posedge clk_i); #1;
      case (tx_rdy_mode)
        0: tx_ready_and_i = 1'b0;
        1: tx_ready_and_i = 1'b1;
        2: tx_ready_and_i = 1'($urandom_range(0, 1));
        default: tx_ready_and_i = ~tx_ready_and_i;
      endcase
      case (rx_rdy_mode)
        0: nbf_ready_and_i = 1'b0;
        1: nbf_ready_and_i = 1'b1;
        2: nbf_ready_and_i = 1'($urandom_range(0, 1));
        default: nbf_ready_and_i = ~nbf_ready_and_i;
      endcase
    end
  end

  // TX monitor: compare each transferred byte, and stability while stalled.
  initial begin
    logic [7:0] prev;
    bit stalled;
    stalled = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk_i);
      if (!reset_n_i || !sb_en) begin
        stalled = 1'b0;
        continue;
      end
      if (tx_v_o) begin
        if (stalled) check("tx_stall_stable", tx_o, prev);
        if (tx_ready_and_i) begin
          if (tx_exp_q.size() == 0) fail_now("tx_unexpected_byte");
          else check("tx_byte", tx_o, tx_exp_q.pop_front());
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          prev = tx_o;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  // RX monitor: compare delivered packets, hold behaviour, count timeout pulses.
  initial begin
    logic [111:0] prevp;
    bit held;
    held = 1'b0;
    prevp = '0;
    forever begin
      @(negedge clk_i);
      if (!reset_n_i) begin
        held = 1'b0;
        continue;
      end
      if (rx_timeout_o) tmo_pulses++;
      if (!sb_en) begin
        held = 1'b0;
        continue;
      end
      if (nbf_v_o) begin
        if (held) check("rx_hold_stable", nbf_o, prevp);
        if (rx_v_i) check("rx_yumi_in_hold", rx_yumi_o, 0);
        if (nbf_ready_and_i) begin
          if (rx_exp_q.size() == 0) fail_now("rx_unexpected_pkt");
          else check("rx_pkt", nbf_o, rx_exp_q.pop_front());
          held = 1'b0;
        end else begin
          held = 1'b1;
          prevp = nbf_o;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic tx_send(input logic [111:0] p, input bit push);
    int n;
    bit ok;
    nbf_i = p;
    nbf_v_i = 1'b1;
    if (push) for (int k = 0; k < 14; k++) tx_exp_q.push_back(p[8*k +: 8]);
    n = 0;
    ok = 1'b0;
    while (!ok && n < 400) begin
      @(negedge clk_i);
      ok = nbf_ready_and_o;
      @(posedge clk_i); #1;
      n++;
    end
    nbf_v_i = 1'b0;
    if (!ok) fail_now("tx_accept_timeout");
    else if (push) tx_sent++;
  endtask

  task automatic rx_send_byte(input logic [7:0] b);
    int n;
    bit ok;
    rx_i = b;
    rx_v_i = 1'b1;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 400) begin
      @(negedge clk_i);
      ok = rx_yumi_o;
      @(posedge clk_i); #1;
      n++;
    end
    rx_v_i = 1'b0;
    if (!ok) fail_now("rx_yumi_timeout");
  endtask

  task automatic rx_send_pkt(input logic [111:0] p, input int gap_max);
    rx_exp_q.push_back(p);
    rx_sent++;
    for (int k = 0; k < 14; k++) begin
      rx_send_byte(p[8*k +: 8]);
      if (k < 13) idle($urandom_range(0, gap_max));
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((tx_exp_q.size() != 0 || rx_exp_q.size() != 0 || !nbf_ready_and_o) && n < 4000) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (n >= 4000) fail_now("drain_timeout");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_nbf_ready"}, nbf_ready_and_o, 1);
    check({tag, "_tx_v"}, tx_v_o, 0);
    check({tag, "_tx_o"}, tx_o, 0);
    check({tag, "_rx_yumi"}, rx_yumi_o, 0);
    check({tag, "_nbf_v"}, nbf_v_o, 0);
    check({tag, "_nbf_o"}, nbf_o, 0);
    check({tag, "_timeout"}, rx_timeout_o, 0);
    check({tag, "_tx_cnt"}, tx_pkt_count_o, 0);
    check({tag, "_rx_cnt"}, rx_pkt_count_o, 0);
  endtask

  initial begin
    logic [111:0] p;
    int c;
    int t0;

    // Reset state, with a byte offered to prove rx_yumi_o stays low.
    rx_v_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_reset_outputs("reset");
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    rx_v_i = 1'b0;
    sb_en = 1'b1;
    idle(2);

    // TX single packet, full-rate sink.
    p = {8'h03, 40'h00_8000_0000, 64'h1122334455667788};
    tx_send(p, 1'b1);
    c = 0;
    do begin
      @(negedge clk_i);
      c++;
    end while (!nbf_ready_and_o && c < 100);
    check("tx_ready_return_cycle", 32'(c), 15);
    check("tx_count_single", tx_pkt_count_o, 1);
    @(posedge clk_i); #1;

    // TX backpressure with a toggling sink.
    tx_rdy_mode = 3;
    tx_send(rand_pkt(), 1'b1);
    tx_send(rand_pkt(), 1'b1);
    wait_drain();
    tx_rdy_mode = 1;
    check("tx_count_bp", tx_pkt_count_o, 32'(tx_sent));

    // RX assembly then hold while the consumer stalls.
    rx_rdy_mode = 0;
    idle(2);
    p = {8'h13, 40'h00_0011_0000, 64'h0};
    rx_send_pkt(p, 0);
    rx_i = 8'hAA;
    rx_v_i = 1'b1;
    repeat (5) begin
      @(negedge clk_i);
      check("rx_hold_valid", nbf_v_o, 1);
      check("rx_hold_data", nbf_o, p);
      @(posedge clk_i); #1;
    end
    rx_v_i = 1'b0;
    rx_rdy_mode = 1;
    wait_drain();
    check("rx_count_hold", rx_pkt_count_o, 32'(rx_sent));

    // A 15-cycle gap mid-packet is within the limit.
    t0 = tmo_pulses;
    p = rand_pkt();
    rx_exp_q.push_back(p);
    rx_sent++;
    for (int k = 0; k < 14; k++) begin
      rx_send_byte(p[8*k +: 8]);
      if (k == 6) idle(15);
    end
    wait_drain();
    check("rx_no_timeout_gap15", 32'(tmo_pulses - t0), 0);

    // Partial packet, long idle: one pulse, then a clean packet.
    t0 = tmo_pulses;
    for (int k = 0; k < 5; k++) rx_send_byte(8'($urandom));
    idle(20);
    check("rx_timeout_pulse", 32'(tmo_pulses - t0), 1);
    rx_send_pkt(rand_pkt(), 2);
    wait_drain();
    check("rx_count_after_tmo", rx_pkt_count_o, 32'(rx_sent));

    // Byte arriving exactly in the timeout cycle starts a new packet.
    t0 = tmo_pulses;
    for (int k = 0; k < 5; k++) rx_send_byte(8'($urandom));
    idle(16);
    rx_send_pkt(rand_pkt(), 1);
    wait_drain();
    check("rx_timeout_edge_pulse", 32'(tmo_pulses - t0), 1);
    check("rx_count_tmo_edge", rx_pkt_count_o, 32'(rx_sent));

    // Full duplex with random backpressure on both sinks.
    tx_rdy_mode = 2;
    rx_rdy_mode = 2;
    fork
      begin
        for (int i = 0; i < 3; i++) tx_send(rand_pkt(), 1'b1);
      end
      begin
        for (int i = 0; i < 3; i++) rx_send_pkt(rand_pkt(), 3);
      end
    join
    tx_rdy_mode = 1;
    rx_rdy_mode = 1;
    wait_drain();
    check("duplex_tx_count", tx_pkt_count_o, 32'(tx_sent));
    check("duplex_rx_count", rx_pkt_count_o, 32'(rx_sent));

    // Asynchronous reset in the middle of both directions.
    sb_en = 1'b0;
    fork
      begin
        tx_send(rand_pkt(), 1'b0);
        idle(6);
      end
      begin
        for (int k = 0; k < 10; k++) rx_send_byte(8'($urandom));
      end
    join
    rx_i = 8'h5A;
    rx_v_i = 1'b1;
    #2;
    reset_n_i = 1'b0;
    #1;
    check_reset_outputs("midreset");
    idle(2);
    reset_n_i = 1'b1;
    rx_v_i = 1'b0;
    tx_sent = 0;
    rx_sent = 0;
    idle(1);
    sb_en = 1'b1;
    fork
      tx_send(rand_pkt(), 1'b1);
      rx_send_pkt(rand_pkt(), 1);
    join
    wait_drain();
    check("post_reset_tx_count", tx_pkt_count_o, 32'(tx_sent));
    check("post_reset_rx_count", rx_pkt_count_o, 32'(rx_sent));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
